// File: rtl/branch_resolve_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_ctrl_if
//  Description : Bundle of the EX-stage branch resolution signals shared
//                between the pipeline (master) and branch_resolve_ctrl (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_ctrl_if #(
    parameter int CNT_W = 16
);
    // Instruction and comparator side
    logic              i_valid;
    logic              i_is_br;
    logic              i_is_jal;
    logic              i_is_jalr;
    logic [2:0]        i_funct3;
    logic [31:0]       i_pc;
    logic [31:0]       i_target;
    logic [31:0]       i_pred_pc;
    logic              i_br_less;
    logic              i_br_equal;
    logic              i_redirect_ready;
    logic              i_cnt_clr;

    // Controller results
    logic              o_br_un;
    logic              o_redirect_valid;
    logic [31:0]       o_redirect_pc;
    logic              o_flush;
    logic              o_br_illegal;
    logic [CNT_W-1:0]  o_br_cnt;
    logic [CNT_W-1:0]  o_mispred_cnt;

    modport master (
        output i_valid, i_is_br, i_is_jal, i_is_jalr, i_funct3, i_pc,
               i_target, i_pred_pc, i_br_less, i_br_equal,
               i_redirect_ready, i_cnt_clr,
        input  o_br_un, o_redirect_valid, o_redirect_pc, o_flush,
               o_br_illegal, o_br_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_valid, i_is_br, i_is_jal, i_is_jalr, i_funct3, i_pc,
               i_target, i_pred_pc, i_br_less, i_br_equal,
               i_redirect_ready, i_cnt_clr,
        output o_br_un, o_redirect_valid, o_redirect_pc, o_flush,
               o_br_illegal, o_br_cnt, o_mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_ctrl
//  Description : EX-stage branch resolution. Selects the comparator's signed/
//                unsigned mode, derives the taken decision, compares the real
//                next PC with the prediction and runs a redirect/flush
//                handshake with fetch on a mismatch. Keeps saturating branch
//                and misprediction counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    branch_resolve_ctrl_if.slave   bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0]       c_ST_IDLE     = 1'b0;
    localparam logic [0:0]       c_ST_REDIRECT = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [31:0]      c_INSTR_BYTES = 32'd4;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_redirect_valid;
    logic             w_flush;

    logic [31:0]      r_redirect_pc;
    logic             r_br_illegal;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_sel_jalr;
    logic             w_sel_jal;
    logic             w_sel_br;
    logic             w_resolve;
    logic             w_cond_taken;
    logic             w_f3_illegal;
    logic             w_taken;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_actual_pc;
    logic             w_mispred;
    logic             w_br_inc;

    // ------------------------------------------------------------------
    // Comparator mode: only BLTU/BGEU compare unsigned. Driven straight
    // from funct3 so the flags come back within the same cycle.
    // ------------------------------------------------------------------
    assign bus.o_br_un = (bus.i_funct3 == 3'b110) || (bus.i_funct3 == 3'b111);

    // ------------------------------------------------------------------
    // Instruction type selection. Multiple flags can be raised by a
    // sloppy decoder; JALR wins over JAL, JAL wins over a branch.
    // ------------------------------------------------------------------
    assign w_sel_jalr = bus.i_is_jalr;
    assign w_sel_jal  = !bus.i_is_jalr && bus.i_is_jal;
    assign w_sel_br   = !bus.i_is_jalr && !bus.i_is_jal && bus.i_is_br;

    // Instructions presented while redirecting are on the wrong path and
    // therefore never resolve.
    assign w_resolve  = (r_state == c_ST_IDLE) && bus.i_valid &&
                        (bus.i_is_br || bus.i_is_jal || bus.i_is_jalr);

    // Conditional branch decision from funct3 and the comparator flags
    always_comb begin
        w_cond_taken = 1'b0;
        w_f3_illegal = 1'b0;
        case (bus.i_funct3)
            3'b000:         w_cond_taken = bus.i_br_equal;
            3'b001:         w_cond_taken = !bus.i_br_equal;
            3'b100, 3'b110: w_cond_taken = bus.i_br_less;
            3'b101, 3'b111: w_cond_taken = !bus.i_br_less;
            default:        w_f3_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-PC computation. JALR targets are forced halfword-aligned by
    // clearing bit 0; the sequential PC simply wraps at 2^32.
    // ------------------------------------------------------------------
    assign w_taken     = w_sel_jalr || w_sel_jal || (w_sel_br && w_cond_taken);
    assign w_target    = w_sel_jalr ? {bus.i_target[31:1], 1'b0} : bus.i_target;
    assign w_pc_plus4  = bus.i_pc + c_INSTR_BYTES;
    assign w_actual_pc = w_taken ? w_target : w_pc_plus4;
    assign w_mispred   = w_resolve && (w_actual_pc != bus.i_pred_pc);
    assign w_br_inc    = w_resolve && w_sel_br;

    // ------------------------------------------------------------------
    // Redirect FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: enter REDIRECT on a mispredict, leave on the handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_mispred) begin
                    w_state_nxt = c_ST_REDIRECT;
                end
            end
            c_ST_REDIRECT: begin
                if (w_redirect_valid && bus.i_redirect_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs: redirect request and pipeline squash share the REDIRECT state
    always_comb begin
        w_redirect_valid = 1'b0;
        w_flush          = 1'b0;
        if (r_state == c_ST_REDIRECT) begin
            w_redirect_valid = 1'b1;
            w_flush          = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Capture the correct next PC on a mispredict; held through the wait
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect_pc <= 32'd0;
        end else if (w_mispred) begin
            r_redirect_pc <= w_actual_pc;
        end
    end

    // One-cycle pulse for a resolved branch carrying a reserved funct3
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_br_illegal <= 1'b0;
        end else begin
            r_br_illegal <= w_br_inc && w_f3_illegal;
        end
    end

    // Saturating count of resolved conditional branches; clear wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_br_cnt <= '0;
        end else if (bus.i_cnt_clr) begin
            r_br_cnt <= '0;
        end else if (w_br_inc && (r_br_cnt != c_CNT_MAX)) begin
            r_br_cnt <= r_br_cnt + 1'b1;
        end
    end

    // Saturating count of mispredicted control transfers; clear wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mispred_cnt <= '0;
        end else if (bus.i_cnt_clr) begin
            r_mispred_cnt <= '0;
        end else if (w_mispred && (r_mispred_cnt != c_CNT_MAX)) begin
            r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.o_redirect_valid = w_redirect_valid;
    assign bus.o_flush          = w_flush;
    assign bus.o_redirect_pc    = r_redirect_pc;
    assign bus.o_br_illegal     = r_br_illegal;
    assign bus.o_br_cnt         = r_br_cnt;
    assign bus.o_mispred_cnt    = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_ctrl
//  Description : Self-checking bench for branch_resolve_ctrl. Directed
//                scenarios plus randomized traffic against an ISA-level
//                reference model. Counters use a narrow width so that
//                saturation is reachable quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    localparam int            CW   = 4;
    localparam logic [CW-1:0] MAXC = {CW{1'b1}};

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    branch_resolve_ctrl_if #(.CNT_W(CW)) bus ();

    branch_resolve_ctrl #(.CNT_W(CW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit            m_redir;
    logic [31:0]   m_rpc;
    logic [CW-1:0] m_brc;
    logic [CW-1:0] m_misc;
    bit            m_ill;
    logic [31:0]   rs1, rs2;

    // ISA meaning of each branch condition, evaluated on operand values
    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Present an instruction; the bench plays the comparator from rs1/rs2
    task automatic set_instr(input bit v, input bit br, input bit jal, input bit jalr,
                             input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic [31:0] pred,
                             input logic [31:0] a, input logic [31:0] b);
        bus.i_valid = v;  bus.i_is_br = br; bus.i_is_jal = jal; bus.i_is_jalr = jalr;
        bus.i_funct3 = f3; bus.i_pc = pc; bus.i_target = tgt; bus.i_pred_pc = pred;
        rs1 = a; rs2 = b;
        bus.i_br_equal = (a == b);
        if (f3 == 3'd6 || f3 == 3'd7) bus.i_br_less = (a < b);
        else                          bus.i_br_less = ($signed(a) < $signed(b));
    endtask

    task automatic idle_in();
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic model_reset();
        m_redir = 1'b0; m_rpc = 32'd0; m_brc = '0; m_misc = '0; m_ill = 1'b0;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge
    task automatic tick();
        bit            n_redir, n_ill, inc_b, inc_m;
        logic [31:0]   n_rpc, nxt;
        n_redir = m_redir; n_rpc = m_rpc; n_ill = 1'b0; inc_b = 1'b0; inc_m = 1'b0;
        if (m_redir) begin
            if (bus.i_redirect_ready) n_redir = 1'b0;
        end else if (bus.i_valid && (bus.i_is_br || bus.i_is_jal || bus.i_is_jalr)) begin
            if (bus.i_is_jalr)     nxt = bus.i_target & ~32'h1;
            else if (bus.i_is_jal) nxt = bus.i_target;
            else begin
                inc_b = 1'b1;
                n_ill = (bus.i_funct3 == 3'd2) || (bus.i_funct3 == 3'd3);
                nxt   = ref_taken(bus.i_funct3, rs1, rs2) ? bus.i_target : bus.i_pc + 32'd4;
            end
            if (nxt != bus.i_pred_pc) begin
                inc_m = 1'b1; n_redir = 1'b1; n_rpc = nxt;
            end
        end
        @(posedge i_clk);
        #1;
        m_redir = n_redir; m_rpc = n_rpc; m_ill = n_ill;
        if (bus.i_cnt_clr) begin
            m_brc = '0; m_misc = '0;
        end else begin
            if (inc_b && m_brc  != MAXC) m_brc  = m_brc + 1'b1;
            if (inc_m && m_misc != MAXC) m_misc = m_misc + 1'b1;
        end
    endtask

    task automatic clear_counters();
        idle_in(); bus.i_cnt_clr = 1'b1; tick(); bus.i_cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; idle_in(); bus.i_redirect_ready = 1'b1; bus.i_cnt_clr = 1'b0;
        model_reset();
        @(posedge i_clk); #1;
        n_cmp++; if (bus.o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", bus.o_redirect_valid); end
        n_cmp++; if (bus.o_flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b exp 0", bus.o_flush); end
        n_cmp++; if (bus.o_redirect_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h exp 0", bus.o_redirect_pc); end
        n_cmp++; if (bus.o_br_illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b exp 0", bus.o_br_illegal); end
        n_cmp++; if (bus.o_br_cnt !== '0 || bus.o_mispred_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %h/%h exp 0/0", bus.o_br_cnt, bus.o_mispred_cnt); end
        i_rst_n = 1'b1;
    endtask

    task automatic test_bltu();
        logic [CW-1:0] c0;
        c0 = m_brc;
        set_instr(1, 1, 0, 0, 3'b110, 32'h200, 32'h300, 32'h204, 32'hFFFF_FFFF, 32'h1);
        #1;
        n_cmp++; if (bus.o_br_un !== 1'b1) begin n_err++; $display("FAIL bltu_un: got %b exp 1", bus.o_br_un); end
        n_cmp++; if (bus.i_br_less !== 1'b0) begin n_err++; $display("FAIL bltu_less_setup: got %b exp 0", bus.i_br_less); end
        tick();
        n_cmp++; if (bus.o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL bltu_noredir: got %b exp 0", bus.o_redirect_valid); end
        n_cmp++; if (bus.o_br_cnt !== c0 + 1'b1) begin n_err++; $display("FAIL bltu_brcnt: got %h exp %h", bus.o_br_cnt, c0 + 1'b1); end
        idle_in();
    endtask

    task automatic test_blt_mispredict();
        clear_counters();
        set_instr(1, 1, 0, 0, 3'b100, 32'h100, 32'h80, 32'h104, 32'hFFFF_FFFF, 32'h0);
        #1;
        n_cmp++; if (bus.o_br_un !== 1'b0) begin n_err++; $display("FAIL blt_un: got %b exp 0", bus.o_br_un); end
        tick();
        idle_in();
        n_cmp++; if (bus.o_redirect_valid !== 1'b1) begin n_err++; $display("FAIL blt_valid: got %b exp 1", bus.o_redirect_valid); end
        n_cmp++; if (bus.o_redirect_pc !== 32'h80) begin n_err++; $display("FAIL blt_pc: got %h exp 00000080", bus.o_redirect_pc); end
        n_cmp++; if (bus.o_flush !== 1'b1) begin n_err++; $display("FAIL blt_flush: got %b exp 1", bus.o_flush); end
        n_cmp++; if (bus.o_mispred_cnt !== 1) begin n_err++; $display("FAIL blt_mispcnt: got %h exp 1", bus.o_mispred_cnt); end
        bus.i_redirect_ready = 1'b1;
        tick();
        n_cmp++; if (bus.o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL blt_done: got %b exp 0", bus.o_redirect_valid); end
    endtask

    task automatic test_jalr();
        set_instr(1, 0, 0, 1, 3'd0, 32'h1000, 32'h203, 32'h202, 32'd0, 32'd0);
        tick();
        n_cmp++; if (bus.o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL jalr_masked: got %b exp 0", bus.o_redirect_valid); end
        set_instr(1, 0, 0, 1, 3'd0, 32'h1000, 32'h203, 32'h200, 32'd0, 32'd0);
        tick();
        idle_in();
        n_cmp++; if (bus.o_redirect_valid !== 1'b1 || bus.o_redirect_pc !== 32'h202) begin n_err++; $display("FAIL jalr_redir: got %b/%h exp 1/00000202", bus.o_redirect_valid, bus.o_redirect_pc); end
        tick();
    endtask

    task automatic test_redirect_wait();
        clear_counters();
        bus.i_redirect_ready = 1'b0;
        set_instr(1, 1, 0, 0, 3'b000, 32'h400, 32'h500, 32'h404, 32'd5, 32'd5);
        tick();
        // Wrong-path branch that would mispredict if it were resolved
        set_instr(1, 1, 0, 0, 3'b000, 32'h600, 32'h700, 32'h0, 32'd1, 32'd1);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (bus.o_redirect_valid !== 1'b1 || bus.o_flush !== 1'b1 || bus.o_redirect_pc !== 32'h500)
                begin n_err++; $display("FAIL wait_hold[%0d]: got v%b f%b pc %h exp v1 f1 pc 00000500", k, bus.o_redirect_valid, bus.o_flush, bus.o_redirect_pc); end
            if (k == 3) bus.i_redirect_ready = 1'b1;
            tick();
        end
        idle_in();
        n_cmp++; if (bus.o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL wait_release: got %b exp 0", bus.o_redirect_valid); end
        n_cmp++; if (bus.o_br_cnt !== 1 || bus.o_mispred_cnt !== 1) begin n_err++; $display("FAIL wait_cnt: got %h/%h exp 1/1", bus.o_br_cnt, bus.o_mispred_cnt); end
    endtask

    task automatic test_wrap_illegal();
        clear_counters();
        set_instr(1, 1, 0, 0, 3'b001, 32'hFFFF_FFFC, 32'h10, 32'h0, 32'd7, 32'd7);
        tick();
        n_cmp++; if (bus.o_redirect_valid !== 1'b0 || bus.o_br_cnt !== 1) begin n_err++; $display("FAIL wrap_bne: got v%b cnt %h exp v0 cnt 1", bus.o_redirect_valid, bus.o_br_cnt); end
        set_instr(1, 1, 0, 0, 3'b010, 32'h20, 32'h90, 32'h24, 32'd1, 32'd1);
        tick();
        idle_in();
        n_cmp++; if (bus.o_br_illegal !== 1'b1 || bus.o_br_cnt !== 2 || bus.o_redirect_valid !== 1'b0)
            begin n_err++; $display("FAIL illegal_pulse: got ill%b cnt %h v%b exp ill1 cnt 2 v0", bus.o_br_illegal, bus.o_br_cnt, bus.o_redirect_valid); end
        tick();
        n_cmp++; if (bus.o_br_illegal !== 1'b0) begin n_err++; $display("FAIL illegal_oneshot: got %b exp 0", bus.o_br_illegal); end
    endtask

    task automatic test_saturation();
        clear_counters();
        bus.i_redirect_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            set_instr(1, 1, 0, 0, 3'b000, 32'h40, 32'h80, 32'h80, 32'd3, 32'd3);
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            set_instr(1, 0, 1, 0, 3'd0, 32'h40, 32'h80, 32'h44, 32'd0, 32'd0);
            tick(); idle_in(); tick();
        end
        n_cmp++; if (bus.o_br_cnt !== MAXC || bus.o_mispred_cnt !== MAXC) begin n_err++; $display("FAIL sat_reach: got %h/%h exp %h/%h", bus.o_br_cnt, bus.o_mispred_cnt, MAXC, MAXC); end
        set_instr(1, 1, 0, 0, 3'b000, 32'h40, 32'h80, 32'h44, 32'd9, 32'd9);
        tick(); idle_in();
        n_cmp++; if (bus.o_br_cnt !== MAXC || bus.o_mispred_cnt !== MAXC || bus.o_redirect_valid !== 1'b1)
            begin n_err++; $display("FAIL sat_hold: got %h/%h v%b exp %h/%h v1", bus.o_br_cnt, bus.o_mispred_cnt, bus.o_redirect_valid, MAXC, MAXC); end
        tick();
        set_instr(1, 0, 1, 0, 3'd0, 32'h40, 32'h80, 32'h44, 32'd0, 32'd0);
        bus.i_cnt_clr = 1'b1;
        tick();
        bus.i_cnt_clr = 1'b0; idle_in();
        n_cmp++; if (bus.o_br_cnt !== '0 || bus.o_mispred_cnt !== '0 || bus.o_redirect_valid !== 1'b1)
            begin n_err++; $display("FAIL clr_priority: got %h/%h v%b exp 0/0 v1", bus.o_br_cnt, bus.o_mispred_cnt, bus.o_redirect_valid); end
        tick();
    endtask

    task automatic test_async_reset();
        bus.i_redirect_ready = 1'b0;
        set_instr(1, 0, 1, 0, 3'd0, 32'h300, 32'h1234, 32'h304, 32'd0, 32'd0);
        tick(); idle_in();
        n_cmp++; if (bus.o_redirect_valid !== 1'b1 || bus.o_mispred_cnt !== 1'b1) begin n_err++; $display("FAIL arst_setup: got v%b cnt %h exp v1 cnt 1", bus.o_redirect_valid, bus.o_mispred_cnt); end
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (bus.o_redirect_valid !== 1'b0 || bus.o_flush !== 1'b0 || bus.o_redirect_pc !== 32'd0 ||
                     bus.o_br_illegal !== 1'b0 || bus.o_br_cnt !== '0 || bus.o_mispred_cnt !== '0)
            begin n_err++; $display("FAIL arst_clear: got v%b f%b pc %h ill%b cnt %h/%h exp all zero", bus.o_redirect_valid, bus.o_flush, bus.o_redirect_pc, bus.o_br_illegal, bus.o_br_cnt, bus.o_mispred_cnt); end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        bus.i_redirect_ready = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] pc, tgt, pred, a, b, seq, eff;
        logic [2:0]  f3;
        bit          br, jal, jalr;
        for (int k = 0; k < 600; k++) begin
            pc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            tgt  = $urandom();
            a    = $urandom();
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom();
            f3   = 3'($urandom_range(0, 7));
            br   = $urandom_range(0, 3) != 0;
            jal  = $urandom_range(0, 4) == 0;
            jalr = $urandom_range(0, 4) == 0;
            seq  = pc + 32'd4;
            eff  = jalr ? (tgt & ~32'h1) : tgt;
            case ($urandom_range(0, 3))
                0:       pred = seq;
                1:       pred = eff;
                2:       pred = tgt;
                default: pred = $urandom();
            endcase
            set_instr($urandom_range(0, 3) != 0, br, jal, jalr, f3, pc, tgt, pred, a, b);
            bus.i_redirect_ready = $urandom_range(0, 2) != 0;
            bus.i_cnt_clr        = $urandom_range(0, 31) == 0;
            #1;
            n_cmp++; if (bus.o_br_un !== (f3 == 3'd6 || f3 == 3'd7)) begin n_err++; $display("FAIL rnd_un[%0d]: got %b f3 %0d", k, bus.o_br_un, f3); end
            tick();
            n_cmp++; if (bus.o_redirect_valid !== m_redir || bus.o_flush !== m_redir)
                begin n_err++; $display("FAIL rnd_state[%0d]: got v%b f%b exp %b", k, bus.o_redirect_valid, bus.o_flush, m_redir); end
            n_cmp++; if (bus.o_redirect_pc !== m_rpc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h exp %h", k, bus.o_redirect_pc, m_rpc); end
            n_cmp++; if (bus.o_br_illegal !== m_ill) begin n_err++; $display("FAIL rnd_ill[%0d]: got %b exp %b", k, bus.o_br_illegal, m_ill); end
            n_cmp++; if (bus.o_br_cnt !== m_brc || bus.o_mispred_cnt !== m_misc)
                begin n_err++; $display("FAIL rnd_cnt[%0d]: got %h/%h exp %h/%h", k, bus.o_br_cnt, bus.o_mispred_cnt, m_brc, m_misc); end
        end
        bus.i_cnt_clr = 1'b0;
        bus.i_redirect_ready = 1'b1;
        idle_in();
    endtask

    initial begin
        test_reset();
        test_bltu();
        test_blt_mispredict();
        test_jalr();
        test_redirect_wait();
        test_wrap_illegal();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Bound on total run time so a stuck run still terminates
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Branch resolution controller for the EX stage of the pipelined core. It configures the branch comparator's signed/unsigned select from the instruction's funct3, then combines the comparator's less/equal flags into a taken decision. It checks the actual next PC against the predicted next PC and, on a mismatch, runs a redirect/flush handshake with the fetch stage. It also keeps saturating branch and misprediction counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- i_clk  input  1  core clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  the EX-stage instruction is valid.
- i_is_br  input  1  the instruction is a conditional branch (B-type).
- i_is_jal  input  1  the instruction is JAL.
- i_is_jalr  input  1  the instruction is JALR.
- i_funct3  input  3  branch condition code.
- i_pc  input  32  PC of the EX instruction.
- i_target  input  32  computed branch/jump target.
- i_pred_pc  input  32  next PC the front end predicted for this instruction.
- i_br_less  input  1  less flag from the comparator.
- i_br_equal  input  1  equal flag from the comparator.
- i_redirect_ready  input  1  fetch accepts the redirect this cycle.
- i_cnt_clr  input  1  synchronous clear of both counters.
- o_br_un  output  1  comparator unsigned select (combinational).
- o_redirect_valid  output  1  redirect request to fetch.
- o_redirect_pc  output  32  correct next PC.
- o_flush  output  1  squash the IF/ID and ID/EX stage contents.
- o_br_illegal  output  1  one-cycle pulse for a branch with funct3 010 or 011.
- o_br_cnt  output  CNT_W  number of resolved conditional branches.
- o_mispred_cnt  output  CNT_W  number of mispredicted control transfers.

## Operation
- o_br_un = 1 when i_funct3 is 110 (BLTU) or 111 (BGEU), 0 otherwise, regardless of i_is_br.
- Taken decision for a branch, by i_funct3:
  - 000: equal.
  - 001: not equal.
  - 100 and 110: less.
  - 101 and 111: not less.
  - 010 and 011: not taken, and o_br_illegal pulses on the next cycle.
- JAL and JALR are always taken. The JALR target is i_target with bit 0 cleared; the JAL and branch target is i_target unchanged.
- Actual next PC = taken ? target : i_pc + 4, computed mod 2^32 (wraps at 0xFFFFFFFC).
- An instruction resolves when state is IDLE, i_valid = 1, and one of i_is_br / i_is_jal / i_is_jalr is set.
  - If more than one type flag is set, priority is jalr > jal > br.
- Mispredict = the instruction resolves and actual next PC != i_pred_pc.
- FSM states and transitions:
  - IDLE → REDIRECT on mispredict. o_redirect_pc is registered with the actual next PC.
  - REDIRECT → IDLE on the cycle where o_redirect_valid and i_redirect_ready are both 1.
  - Otherwise the FSM holds REDIRECT, with o_redirect_pc stable.
- In REDIRECT, i_valid and all instruction inputs are ignored, because those are wrong-path instructions. No resolution happens and no counter changes.
- o_redirect_valid = o_flush = (state == REDIRECT).
- Counters:
  - o_br_cnt increments on each resolved conditional branch, including illegal funct3.
  - o_mispred_cnt increments on each mispredict.
  - Both saturate at 2^CNT_W − 1.
  - i_cnt_clr has priority over an increment in the same cycle.

## Timing
- Reset values: state IDLE, o_redirect_valid 0, o_flush 0, o_redirect_pc 0, o_br_illegal 0, both counters 0.
- Reset asserted mid-redirect aborts the redirect immediately and asynchronously; no handshake completes.
- Latency:
  - Mispredict detected in cycle N → o_redirect_valid and o_flush high from cycle N+1.
  - Counters reflect cycle N's event at N+1.
- With i_redirect_ready high at N+1: single-cycle redirect, state IDLE at N+2, and a new instruction can resolve in N+2.
- With ready low: redirect and flush hold for each cycle until ready is seen; state returns to IDLE the cycle after the handshake.
- o_br_un has zero latency, so the comparator flags are valid in the same cycle.

## Test plan
- BLTU with rs1=0xFFFFFFFF, rs2=1 (comparator gives less=0), pred_pc=pc+4 → o_br_un=1, no redirect, o_br_cnt +1.
- BLT, less=1, pc=0x100, target=0x80, pred_pc=0x104 → o_redirect_valid at N+1 with o_redirect_pc=0x80, o_flush=1, o_mispred_cnt=1.
- JALR with target 0x203, pred_pc=0x202 → no redirect (target masked to 0x202); with pred_pc=0x200 → redirect to 0x202.
- Mispredict with i_redirect_ready low for 3 cycles → valid/flush held 4 cycles with PC stable; a valid branch presented during the wait is not counted and not resolved.
- BNE not taken at pc=0xFFFFFFFC with pred_pc=0 → no redirect; then funct3=010 → o_br_illegal pulse and o_br_cnt +1.
- Counters at 0xFFFF with CNT_W=16 plus a mispredict → both hold 0xFFFF; i_cnt_clr together with a mispredict → both counters 0; i_rst_n low during REDIRECT → all outputs 0 immediately.
